// File: rtl/sdcard_spi_slave.sv
// SPI mode-0 card-side responder: pins oversampled on clock, bytes exchanged by rx_valid/tx_load handshakes.
// Define SDCARD_SLAVE_CMDFRAME_EN to add the 6-byte SD command framer (index, argument, CRC7 check).
module sdcard_spi_slave #(
   parameter logic [7:0] IDLE_BYTE   = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        spi_cs,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic [7:0]  tx_data,
   input  logic        tx_load,
   output logic        tx_ready,
   output logic        tx_underrun,
   output logic        selected,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_crc_ok
);

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       underrun_q, underrun_d;
   logic       miso_q, miso_d;

   logic       cs_now, cs_old, sclk_rise, sclk_fall, mosi_bit;
   logic [7:0] rx_byte, reload_byte;
   logic       reload_empty, do_reload;

   // All three pins share one chain so CS/SCLK/MOSI ordering is preserved.
   assign cs_now    = cs_sync_q[SYNC_STAGES-2];
   assign cs_old    = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
   assign mosi_bit  = mosi_sync_q[SYNC_STAGES-1];
   assign rx_byte   = {rx_shift_q[6:0], mosi_bit};

   // A load in the same cycle as a reload goes straight into the shifter.
   assign reload_byte  = tx_load ? tx_data : (hold_full_q ? hold_q : IDLE_BYTE);
   assign reload_empty = !tx_load && !hold_full_q;

   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = underrun_q;
      miso_d      = miso_q;
      do_reload   = 1'b0;

      if (tx_load) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
         underrun_d  = 1'b0;
      end

      if (cs_now) begin
         bit_cnt_d = 3'd0;
         miso_d    = 1'b1;
      end else if (cs_old) begin
         bit_cnt_d = 3'd0;
         do_reload = 1'b1;
      end else if (sclk_rise) begin
         rx_shift_d = rx_byte;
         bit_cnt_d  = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            do_reload  = 1'b1;
         end
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
         miso_d     = tx_shift_q[6];
      end

      if (do_reload) begin
         tx_shift_d  = reload_byte;
         miso_d      = reload_byte[7];
         hold_full_d = 1'b0;
         if (reload_empty) underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 8'd0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
         miso_q      <= 1'b1;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
         miso_q      <= miso_d;
      end
   end

   assign spi_miso    = miso_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~hold_full_q;
   assign tx_underrun = underrun_q;
   assign selected    = ~cs_old;

`ifdef SDCARD_SLAVE_CMDFRAME_EN
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic [6:0]  crc_q, crc_d;
   logic [5:0]  wk_idx_q, wk_idx_d;
   logic [31:0] wk_arg_q, wk_arg_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        cmd_crc_ok_q, cmd_crc_ok_d;

   // CRC7, polynomial x^7+x^3+1, MSB first.
   function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] din);
      logic [6:0] c;
      logic       fb;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[6] ^ din[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   always_comb begin
      state_d      = state_q;
      fcnt_d       = fcnt_q;
      crc_d        = crc_q;
      wk_idx_d     = wk_idx_q;
      wk_arg_d     = wk_arg_q;
      cmd_index_d  = cmd_index_q;
      cmd_arg_d    = cmd_arg_q;
      cmd_crc_ok_d = cmd_crc_ok_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid_d && (rx_byte[7:6] == 2'b01)) begin
               wk_idx_d = rx_byte[5:0];
               crc_d    = crc7_byte(7'd0, rx_byte);
               fcnt_d   = 3'd0;
               state_d  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (rx_valid_d) begin
               if (fcnt_q == 3'd4) begin
                  cmd_index_d  = wk_idx_q;
                  cmd_arg_d    = wk_arg_q;
                  cmd_crc_ok_d = (rx_byte[7:1] == crc_q) && rx_byte[0];
                  state_d      = ST_DONE;
               end else begin
                  wk_arg_d = {wk_arg_q[23:0], rx_byte};
                  crc_d    = crc7_byte(crc_q, rx_byte);
                  fcnt_d   = fcnt_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cs_now && (state_q != ST_DONE)) state_d = ST_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         fcnt_q       <= 3'd0;
         crc_q        <= 7'd0;
         wk_idx_q     <= 6'd0;
         wk_arg_q     <= 32'd0;
         cmd_index_q  <= 6'd0;
         cmd_arg_q    <= 32'd0;
         cmd_crc_ok_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         crc_q        <= crc_d;
         wk_idx_q     <= wk_idx_d;
         wk_arg_q     <= wk_arg_d;
         cmd_index_q  <= cmd_index_d;
         cmd_arg_q    <= cmd_arg_d;
         cmd_crc_ok_q <= cmd_crc_ok_d;
      end
   end

   assign cmd_valid  = (state_q == ST_DONE);
   assign cmd_index  = cmd_index_q;
   assign cmd_arg    = cmd_arg_q;
   assign cmd_crc_ok = cmd_crc_ok_q;
`else
   assign cmd_valid  = 1'b0;
   assign cmd_index  = 6'd0;
   assign cmd_arg    = 32'd0;
   assign cmd_crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_sdcard_spi_slave.sv
// Directed bench for sdcard_spi_slave: a slow mode-0 master model plus byte/command strobe counters.
module tb_sdcard_spi_slave;

   logic        clock = 1'b0;
   logic        reset_n, spi_cs, spi_sclk, spi_mosi;
   logic        spi_miso, rx_valid, tx_load, tx_ready, tx_underrun, selected;
   logic        cmd_valid, cmd_crc_ok;
   logic [7:0]  rx_data, tx_data;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;

`ifdef SDCARD_SLAVE_CMDFRAME_EN
   localparam bit FRAME_EN = 1'b1;
`else
   localparam bit FRAME_EN = 1'b0;
`endif

   int         n_cmp = 0;
   int         n_bad = 0;
   int         rx_cnt = 0;
   int         cmd_cnt = 0;
   logic [7:0] rx_last = 8'h00;

   always #20 clock = ~clock;

   sdcard_spi_slave #(.IDLE_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
      .selected(selected),
      .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc_ok(cmd_crc_ok)
   );

   always @(negedge clock) begin
      if (rx_valid === 1'b1) begin
         rx_cnt  = rx_cnt + 1;
         rx_last = rx_data;
      end
      if (cmd_valid === 1'b1) cmd_cnt = cmd_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Master: MOSI set at start of a 4-clock low phase, MISO sampled just before SCLK rises.
   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi  = mo[7-i];
         clk(4);
         mi[7-i]   = spi_miso;
         spi_sclk  = 1'b1;
         clk(4);
         spi_sclk  = 1'b0;
      end
      clk(4);
   endtask

   task automatic send_frame(input logic [47:0] f, output logic [7:0] mi0);
      logic [7:0] mi;
      mi0 = 8'h00;
      for (int k = 0; k < 6; k++) begin
         spi_bits(f[47-8*k -: 8], 8, mi);
         if (k == 0) mi0 = mi;
      end
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      clk(6);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      clk(6);
   endtask

   task automatic load_tx(input logic [7:0] b);
      tx_data = b;
      tx_load = 1'b1;
      clk(1);
      tx_load = 1'b0;
      clk(1);
   endtask

   task automatic test_reset();
      clk(3);
      n_cmp++; if (spi_miso !== 1'b1)     begin n_bad++; $display("FAIL reset_miso: got %b want 1", spi_miso); end
      n_cmp++; if (rx_data !== 8'h00)     begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      n_cmp++; if (rx_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_cmp++; if (tx_ready !== 1'b1)     begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
      n_cmp++; if (tx_underrun !== 1'b0)  begin n_bad++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
      n_cmp++; if (selected !== 1'b0)     begin n_bad++; $display("FAIL reset_selected: got %b want 0", selected); end
      n_cmp++; if (cmd_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (cmd_index !== 6'd0)    begin n_bad++; $display("FAIL reset_cmd_index: got %h want 00", cmd_index); end
      n_cmp++; if (cmd_arg !== 32'd0)     begin n_bad++; $display("FAIL reset_cmd_arg: got %h want 0", cmd_arg); end
      n_cmp++; if (cmd_crc_ok !== 1'b0)   begin n_bad++; $display("FAIL reset_crc_ok: got %b want 0", cmd_crc_ok); end
      reset_n = 1'b1;
      clk(4);
   endtask

   task automatic test_cmd0();
      int r0, c0;
      logic [7:0] mi0;
      r0 = rx_cnt; c0 = cmd_cnt;
      cs_low();
      n_cmp++; if (selected !== 1'b1) begin n_bad++; $display("FAIL cmd0_selected: got %b want 1", selected); end
      send_frame(48'h40_00_00_00_00_95, mi0);
      n_cmp++; if (mi0 !== 8'hFF)           begin n_bad++; $display("FAIL cmd0_idle_miso: got %h want FF", mi0); end
      n_cmp++; if (rx_cnt - r0 !== 6)       begin n_bad++; $display("FAIL cmd0_rx_count: got %0d want 6", rx_cnt - r0); end
      n_cmp++; if (rx_last !== 8'h95)       begin n_bad++; $display("FAIL cmd0_rx_last: got %h want 95", rx_last); end
      n_cmp++; if (tx_underrun !== 1'b1)    begin n_bad++; $display("FAIL cmd0_underrun: got %b want 1", tx_underrun); end
      n_cmp++; if (cmd_cnt - c0 !== int'(FRAME_EN)) begin n_bad++; $display("FAIL cmd0_cmd_count: got %0d want %0d", cmd_cnt - c0, FRAME_EN); end
      n_cmp++; if (cmd_index !== 6'd0)      begin n_bad++; $display("FAIL cmd0_index: got %h want 00", cmd_index); end
      n_cmp++; if (cmd_arg !== 32'd0)       begin n_bad++; $display("FAIL cmd0_arg: got %h want 0", cmd_arg); end
      n_cmp++; if (cmd_crc_ok !== FRAME_EN) begin n_bad++; $display("FAIL cmd0_crc_ok: got %b want %b", cmd_crc_ok, FRAME_EN); end
      cs_high();
      n_cmp++; if (selected !== 1'b0) begin n_bad++; $display("FAIL cmd0_deselected: got %b want 0", selected); end
   endtask

   task automatic test_cmd8();
      int c0;
      logic [7:0] mi0;
      c0 = cmd_cnt;
      cs_low();
      send_frame(48'h48_00_00_01_AA_87, mi0);
      n_cmp++; if (cmd_cnt - c0 !== int'(FRAME_EN)) begin n_bad++; $display("FAIL cmd8_cmd_count: got %0d want %0d", cmd_cnt - c0, FRAME_EN); end
      n_cmp++; if (cmd_index !== (FRAME_EN ? 6'd8 : 6'd0)) begin n_bad++; $display("FAIL cmd8_index: got %h", cmd_index); end
      n_cmp++; if (cmd_arg !== (FRAME_EN ? 32'h0000_01AA : 32'd0)) begin n_bad++; $display("FAIL cmd8_arg: got %h", cmd_arg); end
      n_cmp++; if (cmd_crc_ok !== FRAME_EN) begin n_bad++; $display("FAIL cmd8_crc_ok: got %b want %b", cmd_crc_ok, FRAME_EN); end
      // Same CRC bits but end bit 0: must be flagged bad.
      send_frame(48'h48_00_00_01_AA_86, mi0);
      n_cmp++; if (cmd_cnt - c0 !== 2 * int'(FRAME_EN)) begin n_bad++; $display("FAIL cmd8b_cmd_count: got %0d", cmd_cnt - c0); end
      n_cmp++; if (cmd_crc_ok !== 1'b0) begin n_bad++; $display("FAIL cmd8b_crc_ok: got %b want 0", cmd_crc_ok); end
      cs_high();
   endtask

   task automatic test_tx_queue();
      logic [7:0] mi;
      load_tx(8'h01);
      n_cmp++; if (tx_ready !== 1'b0)    begin n_bad++; $display("FAIL tx_ready_after_load: got %b want 0", tx_ready); end
      n_cmp++; if (tx_underrun !== 1'b0) begin n_bad++; $display("FAIL tx_load_clears_underrun: got %b want 0", tx_underrun); end
      cs_low();
      n_cmp++; if (tx_ready !== 1'b1)    begin n_bad++; $display("FAIL tx_ready_after_csfall: got %b want 1", tx_ready); end
      spi_bits(8'h00, 8, mi);
      n_cmp++; if (mi !== 8'h01)         begin n_bad++; $display("FAIL tx_byte1: got %h want 01", mi); end
      spi_bits(8'h00, 8, mi);
      n_cmp++; if (mi !== 8'hFF)         begin n_bad++; $display("FAIL tx_byte2: got %h want FF", mi); end
      n_cmp++; if (tx_underrun !== 1'b1) begin n_bad++; $display("FAIL tx_underrun_set: got %b want 1", tx_underrun); end
      load_tx(8'hFE);
      n_cmp++; if (tx_underrun !== 1'b0) begin n_bad++; $display("FAIL tx_underrun_clear: got %b want 0", tx_underrun); end
      spi_bits(8'h00, 8, mi);
      n_cmp++; if (mi !== 8'hFF)         begin n_bad++; $display("FAIL tx_byte3: got %h want FF", mi); end
      spi_bits(8'h00, 8, mi);
      n_cmp++; if (mi !== 8'hFE)         begin n_bad++; $display("FAIL tx_byte4: got %h want FE", mi); end
      cs_high();
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi;
      load_tx(8'h11);
      load_tx(8'h22);
      cs_low();
      spi_bits(8'h00, 8, mi);
      n_cmp++; if (mi !== 8'h22) begin n_bad++; $display("FAIL tx_overwrite: got %h want 22", mi); end
      cs_high();
   endtask

   task automatic test_partial_byte();
      int r0;
      logic [7:0] mi;
      r0 = rx_cnt;
      cs_low();
      spi_bits(8'hF0, 4, mi);
      cs_high();
      cs_low();
      spi_bits(8'hA5, 8, mi);
      cs_high();
      n_cmp++; if (rx_cnt - r0 !== 1) begin n_bad++; $display("FAIL partial_rx_count: got %0d want 1", rx_cnt - r0); end
      n_cmp++; if (rx_last !== 8'hA5) begin n_bad++; $display("FAIL partial_rx_data: got %h want A5", rx_last); end
   endtask

   task automatic test_frame_abort();
      int c0;
      logic [7:0] mi, mi0;
      c0 = cmd_cnt;
      cs_low();
      spi_bits(8'h40, 8, mi);
      spi_bits(8'h00, 8, mi);
      spi_bits(8'h00, 8, mi);
      cs_high();
      cs_low();
      spi_bits(8'hFF, 8, mi);
      spi_bits(8'hFF, 8, mi);
      cs_high();
      n_cmp++; if (cmd_cnt - c0 !== 0) begin n_bad++; $display("FAIL abort_no_cmd: got %0d want 0", cmd_cnt - c0); end
      cs_low();
      send_frame(48'h40_00_00_00_00_95, mi0);
      cs_high();
      n_cmp++; if (cmd_cnt - c0 !== int'(FRAME_EN)) begin n_bad++; $display("FAIL abort_recover_count: got %0d want %0d", cmd_cnt - c0, FRAME_EN); end
      n_cmp++; if (cmd_index !== 6'd0)      begin n_bad++; $display("FAIL abort_recover_index: got %h want 00", cmd_index); end
      n_cmp++; if (cmd_crc_ok !== FRAME_EN) begin n_bad++; $display("FAIL abort_recover_crc: got %b want %b", cmd_crc_ok, FRAME_EN); end
   endtask

   task automatic test_reset_midbyte();
      int r0;
      logic [7:0] mi;
      cs_low();
      spi_bits(8'hC3, 8, mi);
      load_tx(8'h77);
      spi_bits(8'hFF, 3, mi);
      #7 reset_n = 1'b0;
      #1;
      n_cmp++; if (spi_miso !== 1'b1)    begin n_bad++; $display("FAIL arst_miso: got %b want 1", spi_miso); end
      n_cmp++; if (rx_data !== 8'h00)    begin n_bad++; $display("FAIL arst_rx_data: got %h want 00", rx_data); end
      n_cmp++; if (tx_ready !== 1'b1)    begin n_bad++; $display("FAIL arst_tx_ready: got %b want 1", tx_ready); end
      n_cmp++; if (tx_underrun !== 1'b0) begin n_bad++; $display("FAIL arst_underrun: got %b want 0", tx_underrun); end
      n_cmp++; if (selected !== 1'b0)    begin n_bad++; $display("FAIL arst_selected: got %b want 0", selected); end
      n_cmp++; if (cmd_crc_ok !== 1'b0)  begin n_bad++; $display("FAIL arst_crc_ok: got %b want 0", cmd_crc_ok); end
      clk(2);
      reset_n = 1'b1;
      clk(6);
      r0 = rx_cnt;
      spi_bits(8'h3C, 8, mi);
      n_cmp++; if (rx_cnt - r0 !== 1) begin n_bad++; $display("FAIL arst_next_count: got %0d want 1", rx_cnt - r0); end
      n_cmp++; if (rx_last !== 8'h3C) begin n_bad++; $display("FAIL arst_next_data: got %h want 3C", rx_last); end
      n_cmp++; if (mi !== 8'hFF)      begin n_bad++; $display("FAIL arst_next_miso: got %h want FF", mi); end
      cs_high();
   endtask

   initial begin
      reset_n  = 1'b0;
      spi_cs   = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b1;
      tx_data  = 8'h00;
      tx_load  = 1'b0;
      test_reset();
      test_cmd0();
      test_cmd8();
      test_tx_queue();
      test_back_to_back();
      test_partial_byte();
      test_frame_abort();
      test_reset_midbyte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
